// File: rtl/mcu_pkg.sv
// Shared types and the opcode decoder for multicycle_control_unit.
package mcu_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StWriteback = 3'd4,
    StHalt      = 3'd5
  } state_t;

  localparam logic [7:0] OP_ADD  = 8'd0;
  localparam logic [7:0] OP_SUB  = 8'd1;
  localparam logic [7:0] OP_AND  = 8'd2;
  localparam logic [7:0] OP_OR   = 8'd3;
  localparam logic [7:0] OP_ADDI = 8'd4;
  localparam logic [7:0] OP_SUBI = 8'd5;
  localparam logic [7:0] OP_ANDI = 8'd6;
  localparam logic [7:0] OP_BR   = 8'd7;

  localparam logic [1:0] ALU_BR = 2'b11;

  typedef struct packed {
    logic       alusrc;
    logic [7:0] aluctrl;
    logic       is_branch;
    logic       illegal;
  } ctrl_t;

  // Opcode arrives zero-extended; illegal opcodes decode to all-zero controls.
  function automatic ctrl_t decode_op(input logic [31:0] op);
    ctrl_t c;
    c = '0;
    if (op > 32'(OP_BR)) begin
      c.illegal = 1'b1;
    end else if (op == 32'(OP_BR)) begin
      c.is_branch = 1'b1;
      c.alusrc    = 1'b1;
      c.aluctrl   = {6'b0, ALU_BR};
    end else begin
      c.alusrc  = (op >= 32'(OP_ADDI));
      c.aluctrl = op[7:0];
    end
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_unit.sv
// FETCH/DECODE/EXECUTE/WRITEBACK sequencer with registered decode and illegal-opcode halt.
// Optional MCU_PERF_CNT_EN adds cycle and retired-instruction counters.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int unsigned OPCODE_W  = 4,
  parameter int unsigned ALUCTRL_W = 2
`ifdef MCU_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W     = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 zero,
  input  logic                 imem_ack,
  output logic                 imem_req,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCSrc,
  output logic                 RegWrite,
  output logic                 ALUSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Branch,
  output logic                 halted
`ifdef MCU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     cyc_cnt,
  output logic [CNT_W-1:0]     retired_cnt
`endif
);

  state_t               state_q, state_d;
  logic                 alusrc_q, alusrc_d;
  logic                 is_branch_q, is_branch_d;
  logic [ALUCTRL_W-1:0] aluctrl_q, aluctrl_d;
  ctrl_t                dec;

  always_comb dec = decode_op(32'(opcode));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      alusrc_q    <= 1'b0;
      is_branch_q <= 1'b0;
      aluctrl_q   <= '0;
    end else begin
      state_q     <= state_d;
      alusrc_q    <= alusrc_d;
      is_branch_q <= is_branch_d;
      aluctrl_q   <= aluctrl_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    alusrc_d    = alusrc_q;
    is_branch_d = is_branch_q;
    aluctrl_d   = aluctrl_q;
    imem_req    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCSrc       = 1'b0;
    RegWrite    = 1'b0;
    Branch      = 1'b0;
    // A frozen pipeline holds state and suppresses every strobe.
    if (en) begin
      case (state_q)
        StIdle: state_d = StFetch;
        StFetch: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = StDecode;
          end
        end
        StDecode: begin
          alusrc_d    = dec.alusrc;
          is_branch_d = dec.is_branch;
          aluctrl_d   = ALUCTRL_W'(dec.aluctrl);
          state_d     = dec.illegal ? StHalt : StExecute;
        end
        StExecute: begin
          if (is_branch_q) begin
            Branch  = 1'b1;
            PCWrite = zero;
            PCSrc   = zero;
            state_d = StFetch;
          end else begin
            state_d = StWriteback;
          end
        end
        StWriteback: begin
          RegWrite = 1'b1;
          state_d  = StFetch;
        end
        StHalt: state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
    ALUSrc     = alusrc_q;
    ALUControl = aluctrl_q;
    halted     = (state_q == StHalt);
  end

`ifdef MCU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt     <= '0;
      retired_cnt <= '0;
    end else if (en) begin
      if (state_q != StIdle && state_q != StHalt) begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
      end
      if (state_q == StWriteback || (state_q == StExecute && is_branch_q)) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed scoreboard bench for multicycle_control_unit; checks counters when MCU_PERF_CNT_EN is set.
module tb_multicycle_control_unit;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] opcode;
  logic       zero;
  logic       imem_ack;
  logic       imem_req;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       ALUSrc;
  logic [1:0] ALUControl;
  logic       Branch;
  logic       halted;
`ifdef MCU_PERF_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] retired_cnt;
`endif

  int n_checks;
  int n_fails;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  multicycle_control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .opcode     (opcode),
    .zero       (zero),
    .imem_ack   (imem_ack),
    .imem_req   (imem_req),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .ALUSrc     (ALUSrc),
    .ALUControl (ALUControl),
    .Branch     (Branch),
    .halted     (halted)
`ifdef MCU_PERF_CNT_EN
    ,
    .cyc_cnt    (cyc_cnt),
    .retired_cnt(retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs {imem_req, IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc, ALUControl, Branch, halted}.
  function automatic logic [9:0] ex(input bit req, input bit irw, input bit pcw, input bit pcs,
                                    input bit rw, input bit as, input bit [1:0] ac,
                                    input bit br, input bit hlt);
    return {req, irw, pcw, pcs, rw, as, ac, br, hlt};
  endfunction

  // Queue the expectation, sample at the falling edge, then advance past the next rising edge.
  task automatic cyc(input logic [9:0] expv, input string tag);
    logic [9:0] obs;
    logic [9:0] want;
    string      t;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(negedge clk);
    obs  = {imem_req, IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc, ALUControl, Branch, halted};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    n_checks++;
    assert (obs === want)
    else begin
      n_fails++;
      $error("FAIL %s: outputs got %b expected %b", t, obs, want);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef MCU_PERF_CNT_EN
  task automatic check_perf(input logic [31:0] exp_cyc, input logic [31:0] exp_ret,
                            input string tag);
    n_checks++;
    assert (cyc_cnt === exp_cyc)
    else begin
      n_fails++;
      $error("FAIL %s_cyc: cyc_cnt got %0d expected %0d", tag, cyc_cnt, exp_cyc);
    end
    n_checks++;
    assert (retired_cnt === exp_ret)
    else begin
      n_fails++;
      $error("FAIL %s_ret: retired_cnt got %0d expected %0d", tag, retired_cnt, exp_ret);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    en       = 1'b1;
    opcode   = 4'd0;
    zero     = 1'b0;
    imem_ack = 1'b0;
    #1;

    // Reset, release, then reset again mid-fetch with a stray ack.
    cyc(ex(0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "in_reset");
    rst = 1'b0;
    cyc(ex(0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "idle_after_release");
    cyc(ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 0), "fetch_first");
    rst      = 1'b1;
    imem_ack = 1'b1;
    cyc(ex(0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "rst_mid_fetch");
    rst      = 1'b0;
    imem_ack = 1'b0;
    cyc(ex(0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "idle_again");
    cyc(ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 0), "fetch_no_ack");

    // Immediate ALU op 0101.
    opcode   = 4'b0101;
    imem_ack = 1'b1;
    cyc(ex(1, 1, 1, 0, 0, 0, 2'b00, 0, 0), "alu_fetch");
    imem_ack = 1'b0;
    cyc(ex(0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "alu_decode");
    cyc(ex(0, 0, 0, 0, 0, 1, 2'b01, 0, 0), "alu_execute");
    cyc(ex(0, 0, 0, 0, 1, 1, 2'b01, 0, 0), "alu_wb");

    // Branch taken, then not taken.
    opcode   = 4'b0111;
    imem_ack = 1'b1;
    cyc(ex(1, 1, 1, 0, 0, 1, 2'b01, 0, 0), "br_fetch");
    imem_ack = 1'b0;
    cyc(ex(0, 0, 0, 0, 0, 1, 2'b01, 0, 0), "br_decode");
    zero = 1'b1;
    cyc(ex(0, 0, 1, 1, 0, 1, 2'b11, 1, 0), "br_exec_taken");
    zero     = 1'b0;
    imem_ack = 1'b1;
    cyc(ex(1, 1, 1, 0, 0, 1, 2'b11, 0, 0), "br2_fetch");
    imem_ack = 1'b0;
    cyc(ex(0, 0, 0, 0, 0, 1, 2'b11, 0, 0), "br2_decode");
    cyc(ex(0, 0, 0, 0, 0, 1, 2'b11, 1, 0), "br_exec_not_taken");
`ifdef MCU_PERF_CNT_EN
    check_perf(32'd11, 32'd3, "after_branches");
`endif

    // Five fetch wait states, then a reg-reg op frozen in writeback.
    for (int i = 0; i < 5; i++) begin
      cyc(ex(1, 0, 0, 0, 0, 1, 2'b11, 0, 0), "ack_wait");
    end
    opcode   = 4'b0010;
    imem_ack = 1'b1;
    cyc(ex(1, 1, 1, 0, 0, 1, 2'b11, 0, 0), "ack_arrive");
    imem_ack = 1'b0;
    cyc(ex(0, 0, 0, 0, 0, 1, 2'b11, 0, 0), "wait_decode");
    cyc(ex(0, 0, 0, 0, 0, 0, 2'b10, 0, 0), "rr_execute");
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(ex(0, 0, 0, 0, 0, 0, 2'b10, 0, 0), "wb_frozen");
    end
`ifdef MCU_PERF_CNT_EN
    check_perf(32'd19, 32'd3, "wb_frozen");
`endif
    en = 1'b1;
    cyc(ex(0, 0, 0, 0, 1, 0, 2'b10, 0, 0), "wb_release");
`ifdef MCU_PERF_CNT_EN
    check_perf(32'd20, 32'd4, "wb_release");
`endif
    cyc(ex(1, 0, 0, 0, 0, 0, 2'b10, 0, 0), "post_wb_fetch");

    // Illegal opcode traps into HALT; late acks and zero are ignored.
    opcode   = 4'b1001;
    imem_ack = 1'b1;
    cyc(ex(1, 1, 1, 0, 0, 0, 2'b10, 0, 0), "ill_fetch");
    imem_ack = 1'b0;
    cyc(ex(0, 0, 0, 0, 0, 0, 2'b10, 0, 0), "ill_decode");
    zero = 1'b1;
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0];
      cyc(ex(0, 0, 0, 0, 0, 0, 2'b00, 0, 1), "halt");
    end
`ifdef MCU_PERF_CNT_EN
    check_perf(32'd23, 32'd4, "halt_frozen");
`endif
    imem_ack = 1'b0;
    zero     = 1'b0;
    rst      = 1'b1;
    cyc(ex(0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "halt_reset");
    rst = 1'b0;
    cyc(ex(0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "idle_post_halt");
    cyc(ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 0), "fetch_post_halt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
